// File: rtl/sym_gen_pkg.sv
//==============================================================================
// Module      : sym_gen_pkg
// Description : Shared constants for the symbol generator: symbol table,
//               reset symbol and Galois LFSR tap masks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sym_gen_pkg;

    localparam int         c_SYM_W_DEF     = 8;
    localparam int         c_TABLE_DEPTH   = 16;
    localparam logic [7:0] c_SYM_RESET     = 8'hFF;

    localparam logic [7:0] c_SYM_TABLE [c_TABLE_DEPTH] = '{
        8'hEA, 8'hF1, 8'hD6, 8'h89, 8'h9E, 8'hE5, 8'hB6, 8'hBF,
        8'hDA, 8'hD5, 8'hE6, 8'h9D, 8'hF8, 8'hB3, 8'hF4, 8'hED
    };

    function automatic logic [7:0] sym_lookup(input logic [3:0] idx);
        return c_SYM_TABLE[idx];
    endfunction

    // Right-shifting Galois masks; bit (t-1) set for each maximal-length tap t.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 64'h0000_000C;
            5:       lfsr_taps = 64'h0000_0014;
            6:       lfsr_taps = 64'h0000_0030;
            7:       lfsr_taps = 64'h0000_0060;
            8:       lfsr_taps = 64'h0000_00B8;
            9:       lfsr_taps = 64'h0000_0110;
            10:      lfsr_taps = 64'h0000_0240;
            11:      lfsr_taps = 64'h0000_0500;
            12:      lfsr_taps = 64'h0000_0829;
            13:      lfsr_taps = 64'h0000_100D;
            14:      lfsr_taps = 64'h0000_2015;
            15:      lfsr_taps = 64'h0000_6000;
            17:      lfsr_taps = 64'h0001_2000;
            18:      lfsr_taps = 64'h0002_0400;
            20:      lfsr_taps = 64'h0009_0000;
            24:      lfsr_taps = 64'h00E1_0000;
            32:      lfsr_taps = 64'h8020_0003;
            default: lfsr_taps = 64'h0000_B400;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sym_gen_multi_if.sv
//==============================================================================
// Module      : sym_gen_multi_if
// Description : Control/result bundle between game control and the generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sym_gen_multi_if #(
    parameter int SYM_W  = 8,
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 32,
    parameter int STAT_W = 16
);
    logic              genSym;
    logic [CNT_W-1:0]  symGenMax;
    logic [SYM_W-1:0]  targetSym;
    logic              seedLoad;
    logic [LFSR_W-1:0] seedVal;
    logic              generated;
    logic              special;
    logic [SYM_W-1:0]  generatedSym;
    logic [STAT_W-1:0] symCount;
    logic [STAT_W-1:0] specialCount;

    modport master (
        output genSym, symGenMax, targetSym, seedLoad, seedVal,
        input  generated, special, generatedSym, symCount, specialCount
    );

    modport slave (
        input  genSym, symGenMax, targetSym, seedLoad, seedVal,
        output generated, special, generatedSym, symCount, specialCount
    );
endinterface

`default_nettype wire

// File: rtl/sym_lfsr.sv
//==============================================================================
// Module      : sym_lfsr
// Description : Free-running Galois LFSR with zero-safe seed reload.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sym_lfsr
    import sym_gen_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  wire logic              Clk100M,
    input  wire logic              rstN,
    input  wire logic              load,
    input  wire logic [LFSR_W-1:0] loadVal,
    output logic      [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] c_TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;

    assign w_next = {1'b0, r_state[LFSR_W-1:1]} ^ (r_state[0] ? c_TAPS : '0);
    assign state  = r_state;

    // A zero load would freeze the register forever, so fall back to SEED.
    always_ff @(posedge Clk100M or negedge rstN) begin
        if (!rstN) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (loadVal == '0) ? SEED : loadVal;
        end else begin
            r_state <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sym_gen_multi.sv
//==============================================================================
// Module      : sym_gen_multi
// Description : Periodic pseudo-random symbol generator with special-symbol
//               detection and saturating per-game statistics.
//               Define SYM_GEN_NOREPEAT_EN to forbid back-to-back repeats.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sym_gen_multi
    import sym_gen_pkg::*;
#(
    parameter int                SYM_W       = 8,
    parameter int                TABLE_DEPTH = 16,
    parameter int                LFSR_W      = 16,
    parameter int                CNT_W       = 32,
    parameter int                STAT_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(16'hACE1)
) (
    input  wire logic             Clk100M,
    input  wire logic             rstN,
    sym_gen_multi_if.slave        bus
);

    localparam int c_IDX_W = $clog2(TABLE_DEPTH);

    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_lfsr_unused;
    logic [CNT_W-1:0]   w_eff_max;
    logic               w_start;
    logic               w_emit;
    logic               w_match;
    logic [c_IDX_W-1:0] w_draw;
    logic [c_IDX_W-1:0] w_idx;
    logic [SYM_W-1:0]   w_sym;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_gen_d;
    logic               r_generated;
    logic               r_special;
    logic [SYM_W-1:0]   r_sym;
    logic [STAT_W-1:0]  r_sym_cnt;
    logic [STAT_W-1:0]  r_spc_cnt;

    sym_lfsr #(
        .LFSR_W  (LFSR_W),
        .SEED    (SEED)
    ) u_lfsr (
        .Clk100M (Clk100M),
        .rstN    (rstN),
        .load    (bus.seedLoad),
        .loadVal (bus.seedVal),
        .state   (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr;
    assign w_draw        = w_lfsr[c_IDX_W-1:0];

`ifdef SYM_GEN_NOREPEAT_EN
    logic [c_IDX_W-1:0] r_prev_idx;

    // Index width equals log2(TABLE_DEPTH), so the +1 wraps modulo the depth.
    assign w_idx = (w_draw == r_prev_idx) ? w_draw + c_IDX_W'(1) : w_draw;

    always_ff @(posedge Clk100M or negedge rstN) begin
        if (!rstN) begin
            r_prev_idx <= c_IDX_W'(TABLE_DEPTH - 1);
        end else if (w_emit) begin
            r_prev_idx <= w_idx;
        end
    end
`else
    assign w_idx = w_draw;
`endif

    assign w_sym     = SYM_W'(sym_lookup(4'(w_idx)));
    assign w_match   = (w_sym == bus.targetSym);
    assign w_eff_max = (bus.symGenMax == '0) ? CNT_W'(1) : bus.symGenMax;
    assign w_start   = bus.genSym && !r_gen_d;
    // >= rather than == so a shrinking period fires on the very next cycle.
    assign w_emit    = bus.genSym && (r_cnt >= (w_eff_max - CNT_W'(1)));

    always_ff @(posedge Clk100M or negedge rstN) begin
        if (!rstN) begin
            r_cnt       <= '0;
            r_gen_d     <= 1'b0;
            r_generated <= 1'b0;
            r_special   <= 1'b0;
            r_sym       <= '1;
            r_sym_cnt   <= '0;
            r_spc_cnt   <= '0;
        end else begin
            r_gen_d     <= bus.genSym;
            r_generated <= w_emit;
            r_special   <= w_emit && w_match;
            if (w_emit) begin
                r_sym <= w_sym;
            end
            if (!bus.genSym || w_emit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // A start edge restarts the game; an emit in the same cycle counts as the first.
            if (w_start) begin
                r_sym_cnt <= STAT_W'(w_emit);
                r_spc_cnt <= STAT_W'(w_emit && w_match);
            end else if (w_emit) begin
                if (r_sym_cnt != '1) begin
                    r_sym_cnt <= r_sym_cnt + STAT_W'(1);
                end
                if (w_match && (r_spc_cnt != '1)) begin
                    r_spc_cnt <= r_spc_cnt + STAT_W'(1);
                end
            end
        end
    end

    assign bus.generated    = r_generated;
    assign bus.special      = r_special;
    assign bus.generatedSym = r_sym;
    assign bus.symCount     = r_sym_cnt;
    assign bus.specialCount = r_spc_cnt;

endmodule

`default_nettype wire

// File: doc/sym_gen_multi.md
Name: sym_gen_multi

Overview:
- Parametrised successor to the single-rate symbol generator used in the game period.
- Emits a pseudo-random symbol from a constant symbol table every symGenMax cycles while genSym is high.
- Flags `special` only when the emitted symbol equals a programmable target, and keeps per-game generated and special counts for the scoring logic.
- Sits between the game-control FSM (drives genSym, symGenMax, targetSym) and the display/score path (consumes generated, generatedSym, special).

Parameters:
- SYM_W, 8, symbol width in bits.
- TABLE_DEPTH, 16, number of table entries; power of 2, minimum 2.
- LFSR_W, 16, internal LFSR width; must be ≥ log2(TABLE_DEPTH).
- CNT_W, 32, width of the period counter and symGenMax.
- STAT_W, 16, width of the per-game symbol and special counters.
- SEED, 16'hACE1, LFSR reset and fallback seed; must be nonzero.

Ports:
- Clk100M, in, 1, 100 MHz system clock.
- rstN, in, 1, reset; asynchronous, active-low.
- genSym, in, 1, game period active.
- symGenMax, in, CNT_W, emit period in cycles; 0 is treated as 1.
- targetSym, in, SYM_W, symbol that counts as special.
- seedLoad, in, 1, single-cycle strobe to reload the LFSR.
- seedVal, in, LFSR_W, value loaded on seedLoad.
- generated, out, 1, one-cycle pulse when a symbol is emitted.
- special, out, 1, one-cycle pulse, coincident with generated, when generatedSym == targetSym.
- generatedSym, out, SYM_W, last emitted symbol; holds between emits.
- symCount, out, STAT_W, symbols emitted this game.
- specialCount, out, STAT_W, special symbols emitted this game.

Behaviour:
- Reset (rstN low, asynchronous):
  - generated = 0, special = 0.
  - generatedSym = all ones.
  - symCount = 0, specialCount = 0.
  - Period counter = 0, LFSR = SEED, genSym edge register = 0.
- LFSR:
  - Galois, maximal-length taps for LFSR_W; advances every cycle, including when genSym = 0.
  - seedLoad has priority over advance: loads seedVal, or SEED if seedVal == 0, so the LFSR never locks at zero.
- Table index = LFSR[log2(TABLE_DEPTH)-1:0], sampled in the cycle the emit condition is true.
- Period counter:
  - genSym = 0: counter forced to 0, generated/special = 0, generatedSym holds, counts hold.
  - genSym = 1: counter increments each cycle.
  - When counter ≥ eff_max − 1 (eff_max = max(symGenMax, 1)), next edge: counter ← 0, generated ← 1, generatedSym ← table[index].
  - The ≥ compare means lowering symGenMax mid-period causes an emit on the next cycle.
  - symGenMax = 1 or 0 gives an emit every cycle.
- special:
  - Registered together with generatedSym.
  - Asserts iff the new symbol equals targetSym as sampled in the emit cycle.
- Latency: emit condition to generated/generatedSym/special visible = 1 cycle (registered outputs).
- Game start: on a genSym 0→1 edge (detected against the registered previous value):
  - symCount and specialCount clear to 0.
  - The counter starts from 0, so the first emit occurs eff_max cycles after genSym first goes high.
- Statistics:
  - symCount increments on each emit; specialCount increments on each special emit.
  - Both saturate at 2^STAT_W − 1 and never wrap.
  - Both hold after genSym falls until the next game start.
- Simultaneous events:
  - seedLoad in an emit cycle: the index comes from the pre-load LFSR value.
  - Game-start edge coinciding with an emit: impossible, because the counter is 0 and eff_max > 1. If eff_max == 1, the clear wins and the emit counts as 1.
- Reset mid-game: all state returns to reset values immediately. No emit until genSym is seen low→high or held high for eff_max cycles after rstN deasserts.

Optional Feature:
- Macro SYM_GEN_NOREPEAT_EN.
- Defined:
  - If the drawn index equals the previously emitted index, use (index + 1) mod TABLE_DEPTH instead.
  - Back-to-back emits never repeat a symbol.
  - The previous-index register resets to TABLE_DEPTH−1.
- Undefined: index is used as drawn; repeats are allowed. No previous-index register exists.

Decomposition:
- Package sym_gen_pkg holds:
  - SYM_W default and the TABLE_DEPTH = 16 symbol table constant: EA, F1, D6, 89, 9E, E5, B6, BF, DA, D5, E6, 9D, F8, B3, F4, ED (hex).
  - The reset symbol constant (all ones).
  - The LFSR tap-mask function indexed by LFSR_W.
- One sub-module: sym_lfsr (parameters LFSR_W, SEED; ports clock, reset, load, loadVal, state).

Test Plan:
1. Reset, genSym = 1, symGenMax = 4 for 20 cycles -> generated pulses on cycles 5, 9, 13, 17; symCount = 4; generatedSym is in the table every pulse.
2. seedLoad with seedVal = 0x0001 and targetSym = table[LFSR-predicted index] -> special coincides with generated exactly when the symbols match; specialCount equals the reference-model count.
3. seedLoad with seedVal = 0 -> LFSR reloads SEED (0xACE1) and keeps advancing; no lockup after 2^16 cycles.
4. symGenMax = 0, then 1 -> generated high every cycle; symCount saturates at 0xFFFF with STAT_W = 16 and does not wrap.
5. genSym drop mid-period, then re-raise, with symGenMax = 10 -> counts clear on the rising edge; first emit 10 cycles later; generatedSym held while genSym is low; rstN pulse mid-game returns generatedSym = 0xFF asynchronously.
6. With SYM_GEN_NOREPEAT_EN, force an LFSR seed that repeats an index -> emitted index is +1 mod 16, and no consecutive equal symbols over 10 000 emits. Without the macro, the same seed yields the repeat.
